// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The package is named sub_pkg; the serial datapath and its interface both import it.
package sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
`endif

endinterface

// File: rtl/serial_subtractor_cell.sv
// Single-bit full subtractor: d = a - b - bin, with the borrow out of this bit.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Optional signed overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  sub_state_e       state;
  sub_state_e       next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             borrow_r;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == IDLE) && bus.start;
  assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  full_subtractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SHIFT;
      SHIFT:   if (last_bit)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result registers are left alone on accept so the previous answer stays visible until the first shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_r   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      borrow_r <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      diff_r <= {cell_d, diff_r[WIDTH-1:1]};
      br     <= cell_bo;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        borrow_r <= cell_bo;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
  logic ovf_r;

  // On the last shift cell_d is the result MSB, so overflow lands in the same edge as the final diff bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (last_bit) begin
      ovf_r <= (a_msb != b_msb) & (cell_d != a_msb);
    end
  end

  assign bus.overflow = ovf_r;
`endif

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_r;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the sequential consumer of the half/full subtractor cells in the combinational library. It chains the per-bit difference/borrow across cycles to trade area for latency. It sits behind a start/done handshake so a controller or testbench can issue operations back-to-back.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range WIDTH >= 2.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  WIDTH: minuend; captured on the accepted `start`.
- `b`  in  WIDTH: subtrahend; captured on the accepted `start`.
- `busy`  out  1: high in SHIFT and DONE.
- `done`  out  1: one-cycle pulse when the result is valid.
- `diff`  out  WIDTH: `a - b` mod 2^WIDTH; holds until the next accepted start.
- `borrow_out`  out  1: final borrow; 1 when `a < b` (unsigned); holds with `diff`.
- `overflow`  out  1: signed overflow; present only with `SERIAL_SUB_OVERFLOW_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on `start`.
  - SHIFT -> DONE after WIDTH bit cycles.
  - DONE -> IDLE unconditionally.
- On accept:
  - `a` and `b` are loaded into the A/B shift registers.
  - The borrow flip-flop is cleared.
  - The bit counter is cleared. Counter width is $clog2(WIDTH+1).
  - `diff` and `borrow_out` are not cleared until the first shift.
- Each SHIFT cycle:
  - Take a0 and b0 (the LSBs) and the borrow flip-flop br.
  - d = a0 ^ b0 ^ br.
  - bo = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d is shifted into the `diff` register from the MSB side (right shift), so after WIDTH shifts bit 0 of `diff` is the first computed bit.
  - The A/B registers shift right; br <= bo; the counter increments.
- On the last shift (counter == WIDTH-1), `borrow_out` <= bo.
- `start` in SHIFT or DONE is ignored, not queued.
- `a` and `b` are don't-care outside the accept cycle.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `overflow`=0; internal registers 0.
- Start accepted at edge k:
  - SHIFT occupies cycles k+1 .. k+WIDTH.
  - `done`=1 and the result is valid during cycle k+WIDTH+1.
  - Total latency is WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is sampled in the cycle after `done`.
- `busy` rises in the cycle after accept and falls in the cycle after `done`.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No `done` is generated, and the partial result is discarded.
- Boundary cases:
  - `a == b` gives `diff`=0, `borrow_out`=0.
  - `b == 0` gives `diff`=`a`.
  - `a=0`, `b=2^WIDTH-1` gives `diff`=1, `borrow_out`=1.

## Configuration
- Macro: `SERIAL_SUB_OVERFLOW_EN`.
- Defined:
  - The `overflow` port exists.
  - The MSBs of `a` and `b` are latched on accept.
  - `overflow` is registered together with `diff`: overflow = (a_msb != b_msb) & (diff_msb != a_msb).
  - It is 0 at reset and holds with `diff`.
- Undefined: no `overflow` port and no MSB latches. All other behaviour is identical.

## Structure
- Shared package `sub_pkg`:
  - State encoding enum: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default-width constant `SUB_WIDTH_DEF`=8.
- Sub-module `full_subtractor_cell`:
  - Combinational, ports a, b, bin, d, bout.
  - Instantiated once for the per-bit datapath.
- The FSM, counter and shift registers stay in `serial_subtractor`.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start -> after 9 cycles `done` pulse, `diff`=0x1E, `borrow_out`=0.
- a=0x00, b=0x01 -> `diff`=0xFF, `borrow_out`=1; with macro, `overflow`=0.
- a=0x80, b=0x01 with macro -> `diff`=0x7F, `borrow_out`=0, `overflow`=1.
- a=0x80, b=0x80 -> `diff`=0x00, `borrow_out`=0.
- Pulse `start` with new operands (0xFF, 0x00) during SHIFT and again in the DONE cycle -> ignored; the result equals the first operation. Then a start the cycle after `done` is accepted and yields `diff`=0xFF.
- Assert `rst_n`=0 at cycle 4 of SHIFT -> outputs return to 0 immediately, no `done`. After release, a=0x10, b=0x20 -> `diff`=0xF0, `borrow_out`=1.
